// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared types and constants for the speculative return-address stack
package ras_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int RA_STACK_DEPTH = 8;
    localparam int BR_TAG_NUM     = 8;
    localparam int INST_WIDTH     = 32;
    localparam int BYTE_BIT_WIDTH = 8;

    // Return lands on the instruction after the call.
    localparam int INCR = INST_WIDTH / BYTE_BIT_WIDTH;

    localparam int PTR_W = $clog2(RA_STACK_DEPTH);

    typedef logic [PTR_W-1:0] ras_ptr_t;
    typedef logic [PTR_W:0]   ras_cnt_t;

    typedef struct packed {
        ras_ptr_t              ptr;
        ras_cnt_t              cnt;
        logic [ADDR_WIDTH-1:0] top;
    } ras_cp_t;

endpackage

// File: rtl/ras_cp_table.sv
// rtl/ras_cp_table.sv - per-branch checkpoint register file, one write and one read port
module ras_cp_table
    import ras_pkg::*;
#(
    parameter int BR_NUM = BR_TAG_NUM,
    localparam int BR_TAG = $clog2(BR_NUM)
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              save_en_i,
    input  logic [BR_TAG-1:0] save_tag_i,
    input  ras_cp_t           save_data_i,
    input  logic [BR_TAG-1:0] rd_tag_i,
    output ras_cp_t           rd_data_o
);

    ras_cp_t cp_q [BR_NUM];

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < BR_NUM; i++) begin
                cp_q[i] <= '0;
            end
        end else if (save_en_i) begin
            cp_q[save_tag_i] <= save_data_i;
        end
    end

    assign rd_data_o = cp_q[rd_tag_i];

endmodule

// File: rtl/ras_spec_ctrl.sv
// rtl/ras_spec_ctrl.sv - return-address stack with speculative/committed pointers and branch checkpoints
module ras_spec_ctrl
    import ras_pkg::*;
#(
    parameter int ADDR     = ADDR_WIDTH,
    parameter int RA_DEPTH = RA_STACK_DEPTH,
    parameter int BR_NUM   = BR_TAG_NUM,
    localparam int BR_TAG  = $clog2(BR_NUM),
    localparam int CNT_W   = $clog2(RA_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              fetch_call_,
    input  logic [ADDR-1:0]   fetch_pc,
    input  logic              fetch_ret_,
    output logic              ret_v,
    output logic [ADDR-1:0]   ret_addr,
    output logic [CNT_W-1:0]  spec_cnt,
    input  logic              br_save_,
    input  logic [BR_TAG-1:0] br_save_tag,
    input  logic              br_miss_,
    input  logic [BR_TAG-1:0] br_miss_tag,
    input  logic              commit_call_,
    input  logic              commit_ret_,
    input  logic              flush_
);

    localparam ras_cnt_t CNT_FULL = ras_cnt_t'(RA_DEPTH);

    logic [ADDR-1:0] ent_q [RA_DEPTH];
    ras_ptr_t        sptr_q, sptr_d, cptr_q, cptr_d;
    ras_cnt_t        scnt_q, scnt_d, ccnt_q, ccnt_d;

    logic            push, pop;
    logic [ADDR-1:0] push_val;
    ras_ptr_t        f_sptr;
    ras_cnt_t        f_scnt;
    logic            f_we;
    logic [ADDR-1:0] f_top;

    logic            ent_we;
    ras_ptr_t        ent_widx;
    logic [ADDR-1:0] ent_wdata;
    logic            save_en;
    ras_cp_t         save_data, miss_cp;

    assign push     = !fetch_call_;
    assign pop      = !fetch_ret_;
    assign push_val = fetch_pc + ADDR'(INCR);

    // Fetch-only next state; whenever an entry is written it is the new top.
    always_comb begin
        f_sptr = sptr_q;
        f_scnt = scnt_q;
        f_we   = 1'b0;
        if (push && pop && scnt_q != '0) begin
            f_we = 1'b1;
        end else if (push) begin
            f_sptr = sptr_q + 1'b1;
            f_we   = 1'b1;
            if (scnt_q != CNT_FULL) begin
                f_scnt = scnt_q + 1'b1;
            end
        end else if (pop && scnt_q != '0) begin
            f_sptr = sptr_q - 1'b1;
            f_scnt = scnt_q - 1'b1;
        end
    end

    assign f_top = f_we ? push_val : ent_q[f_sptr];

    always_comb begin
        cptr_d = cptr_q;
        ccnt_d = ccnt_q;
        if (!commit_call_ && commit_ret_) begin
            cptr_d = cptr_q + 1'b1;
            if (ccnt_q != CNT_FULL) begin
                ccnt_d = ccnt_q + 1'b1;
            end
        end else if (commit_call_ && !commit_ret_ && ccnt_q != '0) begin
            cptr_d = cptr_q - 1'b1;
            ccnt_d = ccnt_q - 1'b1;
        end
    end

    // Recovery priority: flush, then mispredict, then normal fetch.
    always_comb begin
        sptr_d    = f_sptr;
        scnt_d    = f_scnt;
        ent_we    = f_we;
        ent_widx  = f_sptr;
        ent_wdata = push_val;
        save_en   = !br_save_;
        save_data = '{ptr: f_sptr, cnt: f_scnt, top: f_top};
        if (!flush_) begin
            sptr_d  = cptr_d;
            scnt_d  = ccnt_d;
            ent_we  = 1'b0;
            save_en = 1'b0;
        end else if (!br_miss_) begin
            sptr_d    = miss_cp.ptr;
            scnt_d    = miss_cp.cnt;
            ent_we    = 1'b1;
            ent_widx  = miss_cp.ptr;
            ent_wdata = miss_cp.top;
            save_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sptr_q <= '0;
            scnt_q <= '0;
            cptr_q <= '0;
            ccnt_q <= '0;
            for (int i = 0; i < RA_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            sptr_q <= sptr_d;
            scnt_q <= scnt_d;
            cptr_q <= cptr_d;
            ccnt_q <= ccnt_d;
            if (ent_we) begin
                ent_q[ent_widx] <= ent_wdata;
            end
        end
    end

    ras_cp_table #(.BR_NUM(BR_NUM)) u_cp_table (
        .clk         (clk),
        .reset_      (reset_),
        .save_en_i   (save_en),
        .save_tag_i  (br_save_tag),
        .save_data_i (save_data),
        .rd_tag_i    (br_miss_tag),
        .rd_data_o   (miss_cp)
    );

    assign ret_addr = ent_q[sptr_q];
    assign ret_v    = (scnt_q != '0);
    assign spec_cnt = scnt_q;

endmodule

// File: doc/ras_spec_ctrl.md
Name: ras_spec_ctrl

Overview:
Speculation-aware controller for the return-address stack. It owns a circular RA buffer with a speculative top pointer driven by fetch, and a committed pointer driven by commit. It takes per-branch checkpoints so that a mispredict or exception flush restores the stack. It sits beside fetch/branch prediction: fetch gets the predicted return target, and the branch unit and commit drive recovery.

Parameters:
ADDR, `AddrWidth (32), address width.
RA_DEPTH, `RaStackDepth (8), number of stack entries; power of 2, at least 2.
BR_NUM, `BrTagNum (8), number of in-flight branch checkpoints.
BR_TAG, $clog2(BR_NUM), branch tag width.

Ports:
clk  in  1  clock
reset_  in  1  asynchronous active-low reset
fetch_call_  in  1  active-low; call fetched, push
fetch_pc  in  ADDR  pc of fetched call
fetch_ret_  in  1  active-low; return fetched, pop
ret_v  out  1  predicted return address valid (spec count != 0)
ret_addr  out  ADDR  predicted return address (top entry)
spec_cnt  out  $clog2(RA_DEPTH)+1  speculative occupancy
br_save_  in  1  active-low; take checkpoint
br_save_tag  in  BR_TAG  checkpoint slot
br_miss_  in  1  active-low; mispredict, restore checkpoint
br_miss_tag  in  BR_TAG  slot to restore
commit_call_  in  1  active-low; call committed
commit_ret_  in  1  active-low; return committed
flush_  in  1  active-low; exception flush, restore committed state

Behaviour:
- One clock, single edge. Reset is asynchronous and active-low (reset_).
- Reset state:
  - all entries = 0; sptr = cptr = 0; scnt = ccnt = 0.
  - ret_v = 0, ret_addr = 0, spec_cnt = 0.
  - checkpoint table cleared.
- Outputs are combinational from registered state, so they reflect the state of the current cycle:
  - ret_addr = ent[sptr]
  - ret_v = (scnt != 0)
  - spec_cnt = scnt
- INCR = `InstWidth/`ByteBitWidth. Pushed value = fetch_pc + INCR, truncated to ADDR bits.
- Fetch update, used only when flush_ and br_miss_ are both inactive:
  - Push only: sptr+1 mod RA_DEPTH; write ent[sptr+1]; scnt saturates at RA_DEPTH.
  - When full, a push overwrites the oldest entry; there is no stall.
  - Pop only: if scnt > 0, sptr-1 mod RA_DEPTH and scnt-1. If scnt == 0, the pop is ignored.
  - Push and pop together: pop then push. If scnt > 0, ent[sptr] is overwritten and sptr/scnt are unchanged. If scnt == 0, it is treated as a plain push.
- Checkpoint (br_save_):
  - cp[br_save_tag] <= {ptr, cnt, top}, taken from the post-fetch-update (next) state of the same cycle.
  - Saving to a live slot overwrites it.
- Mispredict (br_miss_), taking effect on the next cycle:
  - sptr <= cp.ptr, scnt <= cp.cnt, ent[cp.ptr] <= cp.top. This repairs a top entry clobbered on the wrong path.
  - Fetch push/pop and br_save_ in the same cycle are discarded.
  - Deeper entries lost to wrong-path overflow are not recovered; this is accepted.
- Commit pointer update, every cycle, independent of flush/miss:
  - commit_call_ only: cptr+1, ccnt saturating at RA_DEPTH.
  - commit_ret_ only: cptr-1 and ccnt-1 if ccnt > 0.
  - Both: no change.
- Flush (flush_): sptr <= next cptr, scnt <= next ccnt (both including this cycle's commit update). Entry contents are not restored.
- Priority: reset_ > flush_ > br_miss_ > fetch ops. Commit updates are always applied.
- If br_miss_tag names an unsaved slot, the restore uses the stale or reset contents. This is legal and not flagged.
- Latency: a push or pop is visible on ret_addr one cycle later. Recovery is visible one cycle later.

Decomposition:
- Shared package ras_pkg:
  - localparam INCR
  - typedef ras_ptr_t [$clog2(RA_DEPTH)-1:0]
  - typedef ras_cnt_t [$clog2(RA_DEPTH):0]
  - typedef struct ras_cp_t {ras_ptr_t ptr; ras_cnt_t cnt; logic [ADDR-1:0] top;}
- One sub-module, ras_cp_table: a BR_NUM x ras_cp_t register file with one write port (save) and one read port (miss). Asynchronous reset to zero; combinational read.

Test Plan:
1. Reset, then calls at pc 0x100, 0x200, 0x300 on consecutive cycles -> ret_addr 0x304, spec_cnt 3. Three pops -> 0x204, then 0x104, then ret_v = 0. A fourth pop leaves spec_cnt = 0.
2. RA_DEPTH=8, nine calls at pc 0x10..0x90 -> spec_cnt 8, ret_addr 0x94. Eight pops -> last ret_addr 0x24, then ret_v = 0 (0x14 lost).
3. Sequence: call 0x100, br_save_ tag 2, pop, call 0x500, then br_miss_ tag 2 -> next cycle ret_addr 0x104, spec_cnt 1. A same-cycle fetch push is ignored.
4. Sequence: commit_call_ for call 0x100; speculative calls 0x200, 0x300; flush_ -> next cycle spec_cnt 1, ret_addr 0x104. With commit_call_ in the flush cycle as well -> spec_cnt 2.
5. With top 0x104 and scnt 1, assert push (pc 0x700) and pop together -> ret_addr 0x704, spec_cnt 1. Push and pop together on an empty stack -> spec_cnt 1, ret_addr 0x704.
6. Assert reset_ low mid-sequence with scnt 3 and checkpoints live -> outputs go to 0 immediately. A br_miss_ after reset restores ptr 0, cnt 0, top 0.
